// File: rtl/universal_reg_group.sv
// universal_reg_group: 32 x XLEN register file with two read ports, bus and
// load writeback ports, and a single-entry load scoreboard that raises stall.
// Optional build macro: REGFILE_LOAD_FORWARD_EN (load-return forwarding to the
// read ports and hazard clearing in the completion cycle).
module universal_reg_group #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      WRR,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] InputBus3,
  input  logic            load_issue,
  input  logic            mem_wb_valid,
  input  logic [4:0]      mem_wb_rd,
  input  logic [XLEN-1:0] mem_wb_data,
  output logic [XLEN-1:0] UniversalRegOutput1,
  output logic [XLEN-1:0] UniversalRegOutput2,
  output logic            stall,
  output logic            load_busy
);

  localparam int unsigned NREG = 32;
  localparam int unsigned IDXW = 5;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   pend_rd_q, pend_rd_d;
  logic [XLEN-1:0]   regs_q [NREG];

  logic completing;
  logic hazard;
  logic bus_we;
  logic ld_we;
  logic load_accept;

  // The outstanding load returns this cycle.
  assign completing = (state_q == ST_PENDING) && mem_wb_valid && (mem_wb_rd == pend_rd_q);

  // Any use of the pending destination, or a second load, must wait.
  assign hazard = (state_q == ST_PENDING) &&
                  ((WRR[1] && (rs1 == pend_rd_q)) ||
                   (WRR[0] && (rs2 == pend_rd_q)) ||
                   (WRR[2] && (rd  == pend_rd_q)) ||
                   load_issue);

`ifdef REGFILE_LOAD_FORWARD_EN
  // The returning data is forwarded, so the completing load resolves all hazards.
  assign stall = hazard && !completing;
`else
  assign stall = hazard;
`endif

  assign load_busy   = (state_q == ST_PENDING);
  assign bus_we      = WRR[2] && !stall && (rd != '0);
  assign ld_we       = mem_wb_valid && (mem_wb_rd != '0);
  assign load_accept = load_issue && !stall && (rd != '0);

  // Read port 1: array contents (optionally the returning load), gated by WRR[1].
  always_comb begin
    UniversalRegOutput1 = '0;
    if (WRR[1]) begin
      UniversalRegOutput1 = regs_q[rs1];
`ifdef REGFILE_LOAD_FORWARD_EN
      if (mem_wb_valid && (mem_wb_rd != '0) && (rs1 == mem_wb_rd)) begin
        UniversalRegOutput1 = mem_wb_data;
      end
`endif
    end
  end

  // Read port 2: array contents (optionally the returning load), gated by WRR[0].
  always_comb begin
    UniversalRegOutput2 = '0;
    if (WRR[0]) begin
      UniversalRegOutput2 = regs_q[rs2];
`ifdef REGFILE_LOAD_FORWARD_EN
      if (mem_wb_valid && (mem_wb_rd != '0) && (rs2 == mem_wb_rd)) begin
        UniversalRegOutput2 = mem_wb_data;
      end
`endif
    end
  end

  // Register array writes; the bus port wins over a load return to the same index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q[0] <= '0;
      for (int i = 1; i < NREG; i++) begin
        if (bus_we && (rd == IDXW'(i))) begin
          regs_q[i] <= InputBus3;
        end else if (ld_we && (mem_wb_rd == IDXW'(i))) begin
          regs_q[i] <= mem_wb_data;
        end
      end
    end
  end

  // Scoreboard next-state: completion frees the entry, an accepted load claims it.
  always_comb begin
    state_d   = state_q;
    pend_rd_d = pend_rd_q;
    unique case (state_q)
      ST_IDLE: begin
        if (load_accept) begin
          state_d   = ST_PENDING;
          pend_rd_d = rd;
        end
      end
      ST_PENDING: begin
        if (completing) begin
          state_d = ST_IDLE;
        end
        if (load_accept) begin
          state_d   = ST_PENDING;
          pend_rd_d = rd;
        end
      end
    endcase
  end

  // Scoreboard state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pend_rd_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_rd_q <= pend_rd_d;
    end
  end

endmodule
